// File: rtl/ram64_access_ctrl.sv
// Request front-end for the 64-word RAM64: valid/ready request intake, registered
// read response, and a post-reset clear sweep that initialises every word.
module ram64_access_ctrl #(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 6,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RESP
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == '1) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        // Writes complete inside the RAM at this edge; only reads need a response.
        if (req_valid && !req_we) begin
          rsp_data_d  = ram_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  // RAM strobes are gated by rst_n directly so an asserted reset blocks writes at once.
  always_comb begin
    req_ready = rst_n && (state_q == IDLE);
    ram_ld    = 1'b0;
    ram_addr  = req_addr;
    ram_in    = req_wdata;
    if (state_q == CLEAR) begin
      ram_ld   = rst_n;
      ram_addr = clr_cnt_q;
      ram_in   = CLEAR_VALUE;
    end else if (state_q == IDLE) begin
      ram_ld   = rst_n && req_valid && req_we;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

endmodule
